// File: rtl/mem_responder.sv
// Memory responder for the Reptile-8 CPU: req/ack access with
// programmable wait states plus a preload port used while idle.
module mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  state_t state, state_nx;

  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              idle;
  logic              accept;
  logic              go_resp;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req) state_nx = (WC == 4'd0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    idle     = (state == IDLE);
    ack      = (state == RESP);
    busy     = !idle;
    ld_ready = idle & ~req & rst_n;
  end

  // With zero wait states the access completes on the accept edge,
  // so the live request fields are used instead of the latched copy.
  always_comb begin
    accept    = idle & req;
    go_resp   = (state_nx == RESP) && (state != RESP);
    cur_we    = idle ? we    : we_q;
    cur_addr  = idle ? addr  : addr_q;
    cur_wdata = idle ? wdata : wdata_q;
    ram_we    = rst_n & ((go_resp & cur_we) | (ld_en & ld_ready));
    ram_addr  = go_resp ? cur_addr  : ld_addr;
    ram_wdata = go_resp ? cur_wdata : ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= (WC == 4'd0) ? 4'd0 : WC - 4'd1;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (go_resp && !cur_we) rdata <= mem[cur_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: four responders with WAIT_CYCLES 0..3 on one clock,
// each exercised by hand-computed vectors.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n    [4];
  logic        req      [4];
  logic        we       [4];
  logic [11:0] addr     [4];
  logic [7:0]  wdata    [4];
  logic        ack      [4];
  logic [7:0]  rdata    [4];
  logic        busy     [4];
  logic        ld_en    [4];
  logic [11:0] ld_addr  [4];
  logic [7:0]  ld_data  [4];
  logic        ld_ready [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder #(
      .ADDR_W(12), .DATA_W(8), .WAIT_CYCLES(g)
    ) u_dut (
      .clk(clk), .rst_n(rst_n[g]),
      .req(req[g]), .we(we[g]),
      .addr(addr[g]), .wdata(wdata[g]),
      .ack(ack[g]), .rdata(rdata[g]), .busy(busy[g]),
      .ld_en(ld_en[g]), .ld_addr(ld_addr[g]),
      .ld_data(ld_data[g]), .ld_ready(ld_ready[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input int g, input logic [11:0] a,
                      input logic [7:0] d);
    ld_en[g] = 1'b1;
    ld_addr[g] = a;
    ld_data[g] = d;
    tick();
    ld_en[g] = 1'b0;
  endtask

  // Issues one request, drops req after acceptance, returns in ack cycle.
  task automatic access(input int g, input logic w, input logic [11:0] a,
                        input logic [7:0] d, output int lat);
    req[g] = 1'b1;
    we[g] = w;
    addr[g] = a;
    wdata[g] = d;
    tick();
    req[g] = 1'b0;
    lat = 1;
    while (!ack[g] && lat < 20) begin
      tick();
      lat++;
    end
    if (!ack[g]) chk("ack_timeout", 32'(ack[g]), 32'd1);
  endtask

  task automatic wait_ack(input int g, output int n);
    n = 0;
    while (!ack[g] && n < 20) begin
      tick();
      n++;
    end
    if (!ack[g]) chk("ack_timeout", 32'(ack[g]), 32'd1);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0;
      req[i] = 1'b1;
      we[i] = 1'b0;
      addr[i] = '0;
      wdata[i] = '0;
      ld_en[i] = 1'b0;
      ld_addr[i] = '0;
      ld_data[i] = '0;
    end

    // reset with req held high
    tick();
    tick();
    chk("rst_ack", 32'(ack[1]), 32'd0);
    chk("rst_busy", 32'(busy[1]), 32'd0);
    chk("rst_rdata", 32'(rdata[1]), 32'h00);
    chk("rst_ld_ready", 32'(ld_ready[1]), 32'd0);
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    for (int i = 1; i < 4; i++) req[i] = 1'b0;
    #1;
    chk("rel_ld_ready_req1", 32'(ld_ready[0]), 32'd0);
    chk("rel_ld_ready_req0", 32'(ld_ready[1]), 32'd1);
    req[0] = 1'b0;
    #1;
    chk("rel_ld_ready_drop", 32'(ld_ready[0]), 32'd1);

    // loader preload then CPU read, WAIT_CYCLES=1
    load(1, 12'h005, 8'h3C);
    req[1] = 1'b1;
    we[1] = 1'b0;
    addr[1] = 12'h005;
    tick();
    chk("w1_busy_t1", 32'(busy[1]), 32'd1);
    chk("w1_ack_t1", 32'(ack[1]), 32'd0);
    req[1] = 1'b0;
    tick();
    chk("w1_ack_t2", 32'(ack[1]), 32'd1);
    chk("w1_busy_t2", 32'(busy[1]), 32'd1);
    chk("w1_rdata", 32'(rdata[1]), 32'h3C);
    tick();
    chk("w1_ack_idle", 32'(ack[1]), 32'd0);
    chk("w1_busy_idle", 32'(busy[1]), 32'd0);
    chk("w1_rdata_hold", 32'(rdata[1]), 32'h3C);

    // write then read at top address, WAIT_CYCLES=0
    access(0, 1'b1, 12'hFFF, 8'hA5, lat);
    chk("w0_wr_lat", 32'(lat), 32'd1);
    chk("w0_wr_rdata_kept", 32'(rdata[0]), 32'h00);
    tick();
    access(0, 1'b0, 12'hFFF, 8'h00, lat);
    chk("w0_rd_lat", 32'(lat), 32'd1);
    chk("w0_rd_rdata", 32'(rdata[0]), 32'hA5);
    tick();

    // back-to-back reads with req held, WAIT_CYCLES=3
    load(3, 12'h010, 8'h11);
    load(3, 12'h011, 8'h22);
    req[3] = 1'b1;
    we[3] = 1'b0;
    addr[3] = 12'h010;
    tick();
    addr[3] = 12'h011;
    wait_ack(3, lat);
    chk("w3_first_lat", 32'(lat + 1), 32'd4);
    chk("w3_first_rdata", 32'(rdata[3]), 32'h11);
    tick();
    chk("w3_gap_idle", 32'(busy[3]), 32'd0);
    tick();
    chk("w3_second_busy", 32'(busy[3]), 32'd1);
    addr[3] = 12'h010;
    wait_ack(3, lat);
    chk("w3_spacing", 32'(lat + 2), 32'd5);
    chk("w3_second_rdata", 32'(rdata[3]), 32'h22);
    req[3] = 1'b0;
    tick();
    chk("w3_idle", 32'(busy[3]), 32'd0);

    // CPU priority over loader, WAIT_CYCLES=2
    load(2, 12'h020, 8'h44);
    req[2] = 1'b1;
    we[2] = 1'b0;
    addr[2] = 12'h020;
    ld_en[2] = 1'b1;
    ld_addr[2] = 12'h030;
    ld_data[2] = 8'h99;
    #1;
    chk("pri_ld_ready_low", 32'(ld_ready[2]), 32'd0);
    tick();
    chk("pri_busy", 32'(busy[2]), 32'd1);
    req[2] = 1'b0;
    #1;
    chk("pri_ld_ready_busy", 32'(ld_ready[2]), 32'd0);
    wait_ack(2, lat);
    chk("pri_lat", 32'(lat + 1), 32'd3);
    chk("pri_rdata", 32'(rdata[2]), 32'h44);
    tick();
    chk("pri_ld_ready_idle", 32'(ld_ready[2]), 32'd1);
    tick();
    ld_en[2] = 1'b0;

    // reset during a write's wait states
    req[2] = 1'b1;
    we[2] = 1'b1;
    addr[2] = 12'h020;
    wdata[2] = 8'h77;
    tick();
    req[2] = 1'b0;
    chk("rstw_busy", 32'(busy[2]), 32'd1);
    rst_n[2] = 1'b0;
    #1;
    chk("rstw_busy_rst", 32'(busy[2]), 32'd0);
    tick();
    chk("rstw_ack_a", 32'(ack[2]), 32'd0);
    tick();
    chk("rstw_ack_b", 32'(ack[2]), 32'd0);
    rst_n[2] = 1'b1;
    tick();
    access(2, 1'b0, 12'h020, 8'h00, lat);
    chk("rstw_rd_lat", 32'(lat), 32'd3);
    chk("rstw_prior", 32'(rdata[2]), 32'h44);
    tick();
    access(2, 1'b0, 12'h030, 8'h00, lat);
    chk("pri_ld_landed", 32'(rdata[2]), 32'h99);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
